// File: rtl/midi_msg_parser_pkg.sv
// rtl/midi_msg_parser_pkg.sv - shared MIDI constants, parser state and status-decode types
package midi_msg_parser_pkg;

    localparam int MIDI_PAYLOAD_BITS = 8;

    localparam logic [3:0] NOTE_OFF   = 4'h8;
    localparam logic [3:0] NOTE_ON    = 4'h9;
    localparam logic [3:0] POLY_AT    = 4'hA;
    localparam logic [3:0] CONTROL    = 4'hB;
    localparam logic [3:0] PROGRAM    = 4'hC;
    localparam logic [3:0] CHAN_AT    = 4'hD;
    localparam logic [3:0] PITCH_BEND = 4'hE;
    localparam logic [3:0] SYSTEM     = 4'hF;

    localparam logic [7:0] SYSEX    = 8'hF0;
    localparam logic [7:0] MTC_QF   = 8'hF1;
    localparam logic [7:0] SONG_POS = 8'hF2;
    localparam logic [7:0] SONG_SEL = 8'hF3;
    localparam logic [7:0] EOX      = 8'hF7;
    localparam logic [7:0] RT_MIN   = 8'hF8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA1,
        ST_DATA2,
        ST_SKIP,
        ST_SYSEX
    } parseState_t;

    typedef struct packed {
        logic       isNote;
        logic [1:0] dataLen;
        logic       isSysex;
        logic       isRealtime;
        logic       clearsRunning;
    } statusInfo_t;

endpackage

// File: rtl/midi_status_decode.sv
// rtl/midi_status_decode.sv - combinational classification of a MIDI status byte
module midi_status_decode
    import midi_msg_parser_pkg::*;
(
    input  logic [MIDI_PAYLOAD_BITS-1:0] statusByte,
    output statusInfo_t                  info
);

    always_comb begin
        info = '0;
        if (statusByte >= RT_MIN) begin
            info.isRealtime = 1'b1;
        end else if (statusByte[7:4] == SYSTEM) begin
            info.clearsRunning = 1'b1;
            case (statusByte)
                SYSEX:            info.isSysex = 1'b1;
                MTC_QF, SONG_SEL: info.dataLen = 2'd1;
                SONG_POS:         info.dataLen = 2'd2;
                EOX:              info.dataLen = 2'd0;
                default:          info.dataLen = 2'd0;
            endcase
        end else begin
            // data bytes (bit7 = 0) fall through to the all-zero default
            case (statusByte[7:4])
                NOTE_OFF, NOTE_ON: begin
                    info.isNote  = 1'b1;
                    info.dataLen = 2'd2;
                end
                POLY_AT, CONTROL, PITCH_BEND: info.dataLen = 2'd2;
                PROGRAM, CHAN_AT:             info.dataLen = 2'd1;
                default:                      info.dataLen = 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/midi_msg_parser.sv
// rtl/midi_msg_parser.sv - MIDI byte parser emitting Note On/Off events; MIDI_RUNNING_STATUS_EN enables running status
module midi_msg_parser
    import midi_msg_parser_pkg::*;
#(
    parameter logic [3:0] CHANNEL = 4'd0,
    parameter bit         OMNI    = 1'b0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         byteValid_i,
    input  logic [MIDI_PAYLOAD_BITS-1:0] byte_i,
    output logic                         msgValid_o,
    output logic                         noteOn_o,
    output logic [6:0]                   note_o,
    output logic [6:0]                   velocity_o,
    output logic [3:0]                   channel_o
);

`ifdef MIDI_RUNNING_STATUS_EN
    localparam bit RUN_EN = 1'b1;
`else
    localparam bit RUN_EN = 1'b0;
`endif

    parseState_t state, stateNext;
    logic [3:0]  chan, chanNext;
    logic        noteOnStat, noteOnStatNext;
    logic [6:0]  key, keyNext;
    logic [1:0]  skipLeft, skipLeftNext;
    logic [1:0]  skipLen, skipLenNext;
    logic        runOk, runOkNext;
    logic        fire;
    statusInfo_t info;

    midi_status_decode u_decode (
        .statusByte (byte_i),
        .info       (info)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            chan       <= 4'd0;
            noteOnStat <= 1'b0;
            key        <= 7'd0;
            skipLeft   <= 2'd0;
            skipLen    <= 2'd0;
            runOk      <= 1'b0;
        end else begin
            state      <= stateNext;
            chan       <= chanNext;
            noteOnStat <= noteOnStatNext;
            key        <= keyNext;
            skipLeft   <= skipLeftNext;
            skipLen    <= skipLenNext;
            runOk      <= runOkNext;
        end
    end

    always_comb begin
        stateNext      = state;
        chanNext       = chan;
        noteOnStatNext = noteOnStat;
        keyNext        = key;
        skipLeftNext   = skipLeft;
        skipLenNext    = skipLen;
        runOkNext      = runOk;
        fire           = 1'b0;
        if (byteValid_i) begin
            if (byte_i[7]) begin
                // real-time bytes leave every piece of parse state untouched
                if (!info.isRealtime) begin
                    chanNext       = byte_i[3:0];
                    noteOnStatNext = (byte_i[7:4] == NOTE_ON);
                    runOkNext      = !info.clearsRunning;
                    skipLenNext    = info.dataLen;
                    skipLeftNext   = info.dataLen;
                    if (info.isNote)
                        stateNext = ST_DATA1;
                    else if (info.isSysex)
                        stateNext = ST_SYSEX;
                    else if (info.dataLen != 2'd0)
                        stateNext = ST_SKIP;
                    else
                        stateNext = ST_IDLE;
                end
            end else begin
                case (state)
                    ST_DATA1: begin
                        keyNext   = byte_i[6:0];
                        stateNext = ST_DATA2;
                    end
                    ST_DATA2: begin
                        fire      = OMNI || (chan == CHANNEL);
                        stateNext = RUN_EN ? ST_DATA1 : ST_IDLE;
                    end
                    ST_SKIP: begin
                        if (skipLeft == 2'd1) begin
                            skipLeftNext = skipLen;
                            stateNext    = (RUN_EN && runOk) ? ST_SKIP : ST_IDLE;
                        end else begin
                            skipLeftNext = skipLeft - 2'd1;
                        end
                    end
                    default: stateNext = state;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            msgValid_o <= 1'b0;
            noteOn_o   <= 1'b0;
            note_o     <= 7'd0;
            velocity_o <= 7'd0;
            channel_o  <= 4'd0;
        end else begin
            msgValid_o <= fire;
            if (fire) begin
                // a Note On with velocity 0 is reported as Note Off
                noteOn_o   <= noteOnStat && (byte_i[6:0] != 7'd0);
                note_o     <= key;
                velocity_o <= byte_i[6:0];
                channel_o  <= chan;
            end
        end
    end

endmodule

// File: tb/tb_midi_msg_parser.sv
// tb/tb_midi_msg_parser.sv - self-checking bench for midi_msg_parser (channel-0 and omni instances)
module tb_midi_msg_parser;

`ifdef MIDI_RUNNING_STATUS_EN
    localparam bit RS = 1'b1;
`else
    localparam bit RS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       byteValid;
    logic [7:0] byteIn;

    logic       msgValid0, noteOn0, msgValid1, noteOn1;
    logic [6:0] note0, velocity0, note1, velocity1;
    logic [3:0] channel0, channel1;

    int passCount = 0;
    int totalCount = 0;
    int cnt0 = 0, cnt1 = 0;
    int base0, base1;

    logic [18:0] q0[$];
    logic [18:0] q1[$];
    logic [7:0]  mStat;
    logic [7:0]  mBuf[$];

    always #5 clk = ~clk;

    midi_msg_parser #(.CHANNEL(4'd0), .OMNI(1'b0)) dut (
        .clk_i(clk), .rst_i(rst), .byteValid_i(byteValid), .byte_i(byteIn),
        .msgValid_o(msgValid0), .noteOn_o(noteOn0), .note_o(note0),
        .velocity_o(velocity0), .channel_o(channel0)
    );

    midi_msg_parser #(.CHANNEL(4'd0), .OMNI(1'b1)) dutOmni (
        .clk_i(clk), .rst_i(rst), .byteValid_i(byteValid), .byte_i(byteIn),
        .msgValid_o(msgValid1), .noteOn_o(noteOn1), .note_o(note1),
        .velocity_o(velocity1), .channel_o(channel1)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        totalCount++;
        if (got === exp) passCount++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    function automatic int needOf(input logic [7:0] s);
        case (s[7:4])
            4'h8, 4'h9, 4'hA, 4'hB, 4'hE: return 2;
            4'hC, 4'hD: return 1;
            default: return (s == 8'hF2) ? 2 : ((s == 8'hF1 || s == 8'hF3) ? 1 : 0);
        endcase
    endfunction

    // message-level model: a current status plus the data bytes collected so far
    task automatic modelByte(input logic [7:0] b);
        logic [18:0] ev;
        if (b >= 8'hF8) return;
        if (b[7]) begin
            mBuf.delete();
            mStat = (b >= 8'hF4) ? 8'h00 : b;
        end else if (mStat != 8'h00 && mStat != 8'hF0) begin
            mBuf.push_back(b);
            if (mBuf.size() == needOf(mStat)) begin
                if (mStat[7:4] == 4'h8 || mStat[7:4] == 4'h9) begin
                    ev = {((mStat[7:4] == 4'h9) && (b != 8'h00)) ? 1'b1 : 1'b0,
                          mBuf[0][6:0], b[6:0], mStat[3:0]};
                    if (mStat[3:0] == 4'd0) q0.push_back(ev);
                    q1.push_back(ev);
                end
                mBuf.delete();
                if (!RS || mStat[7:4] == 4'hF) mStat = 8'h00;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (msgValid0) begin
                cnt0++;
                chk("dut_pulse_expected", (q0.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                if (q0.size() > 0) chk("dut_event", {noteOn0, note0, velocity0, channel0}, q0.pop_front());
            end
            if (msgValid1) begin
                cnt1++;
                chk("omni_pulse_expected", (q1.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                if (q1.size() > 0) chk("omni_event", {noteOn1, note1, velocity1, channel1}, q1.pop_front());
            end
        end
    end

    task automatic sendByte(input logic [7:0] b);
        @(negedge clk);
        byteValid = 1'b1;
        byteIn = b;
        modelByte(b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            byteValid = 1'b0;
            byteIn = 8'h00;
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        byteValid = 1'b0;
        rst = 1'b1;
        mStat = 8'h00;
        mBuf.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic startTest();
        base0 = cnt0;
        base1 = cnt1;
    endtask

    // bytes are packed first-byte-most-significant in s
    task automatic sendSeq(input int n, input logic [63:0] s);
        for (int i = 0; i < n; i++) sendByte(s[8*(n-1-i) +: 8]);
    endtask

    task automatic endTest(input string name, input int exp0, input int exp1);
        idle(3);
        chk({name, "_dut_missing"}, q0.size(), 0);
        chk({name, "_omni_missing"}, q1.size(), 0);
        chk({name, "_dut_pulses"}, cnt0 - base0, exp0);
        chk({name, "_omni_pulses"}, cnt1 - base1, exp1);
    endtask

    initial begin
        rst = 1'b1;
        byteValid = 1'b0;
        byteIn = 8'h00;
        mStat = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset_state_outputs", {msgValid0, noteOn0, note0, velocity0, channel0}, 0);
        chk("reset_state_omni", {msgValid1, noteOn1, note1, velocity1, channel1}, 0);
        rst = 1'b0;

        startTest(); sendSeq(3, 64'h903C64); endTest("basic_on", 1, 1);
        chk("basic_on_fields", {noteOn0, note0, velocity0, channel0}, {1'b1, 7'h3C, 7'h64, 4'h0});

        startTest(); sendSeq(5, 64'h903C643E00);
        if (RS) begin
            endTest("running", 2, 2);
            chk("running_fields", {noteOn0, note0, velocity0}, {1'b0, 7'h3E, 7'h00});
        end else begin
            endTest("running", 1, 1);
            chk("running_fields", {noteOn0, note0, velocity0}, {1'b1, 7'h3C, 7'h64});
        end

        startTest(); sendSeq(4, 64'h903CF864); endTest("rt_inside", 1, 1);
        chk("rt_inside_fields", {note0, velocity0}, {7'h3C, 7'h64});

        startTest(); sendSeq(3, 64'h914040); endTest("chan1", 0, 1);
        chk("chan1_omni_channel", channel1, 4'h1);

        startTest(); sendSeq(8, 64'hF07E9001F7803C10); endTest("sysex", 1, 1);
        chk("sysex_fields", {noteOn0, note0, velocity0}, {1'b0, 7'h3C, 7'h10});

        startTest(); sendSeq(6, 64'hB0077FC00590); endTest("non_note", 0, 0);

        startTest(); sendSeq(2, 64'h903C); doReset(); sendByte(8'h64); endTest("reset_mid", 0, 0);
        chk("reset_mid_outputs", {noteOn0, note0, velocity0, channel0}, 0);

        startTest(); sendSeq(3, 64'h993C00); endTest("vel0", 0, 1);
        chk("vel0_fields", {noteOn1, note1, velocity1, channel1}, {1'b0, 7'h3C, 7'h00, 4'h9});

        startTest(); sendSeq(3, 64'h851020); endTest("off_ch5", 0, 1);
        chk("off_ch5_fields", {noteOn1, velocity1, channel1}, {1'b0, 7'h20, 4'h5});

        startTest(); sendSeq(5, 64'hA001903C64); endTest("skip_abort", 1, 1);
        startTest(); sendSeq(5, 64'hF201027F7F); endTest("song_pos", 0, 0);
        startTest(); sendSeq(3, 64'hC00506); endTest("program", 0, 0);
        startTest(); sendSeq(4, 64'h903CF064); endTest("sysex_abort", 0, 0);
        startTest(); sendSeq(8, 64'h80F83CF8F810F8F8); endTest("rt_heavy", 1, 1);
        chk("rt_heavy_fields", {noteOn0, note0, velocity0}, {1'b0, 7'h3C, 7'h10});

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
